id_stage_v2: RTL
================

Name: id_stage_v2

Overview:
Parametrised instruction-decode stage for the 5-stage ARM32 pipeline. It sits between the IF/ID register and EXE. It integrates the register file with write-through bypass, condition check, control decode, an internal RAW hazard detector, and an ID/EXE pipeline register with flush and bubble insertion. Upstream stalling is signalled through stall_out.

Parameters:
DATA_W, 32, datapath and PC width
NREGS, 16, architectural register count; RA_W = $clog2(NREGS) is a localparam (must be 4 for the ARM encoding; other values are for test builds only)
FWD_EN, 0, 1 = downstream forwarding exists, so only a load-use hazard stalls; 0 = any RAW hazard on EXE/MEM stalls

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_valid  in  1  instr/pc_in hold a valid instruction
instr  in  32  instruction word
pc_in  in  DATA_W  PC+4 of instr
sr_in  in  4  status flags {N,Z,C,V}
wb_en  in  1  WB-stage register write enable
wb_dst  in  RA_W  WB destination
wb_val  in  DATA_W  WB data
exe_wb_en, exe_mem_r  in  1  EXE-stage instruction writes back / is a load
exe_dst  in  RA_W  EXE-stage destination
mem_wb_en  in  1  MEM-stage instruction writes back
mem_dst  in  RA_W  MEM-stage destination
flush  in  1  branch taken in EXE; kill the instruction in ID
stall_out  out  1  hold PC and IF/ID (combinational)
out_valid  out  1  ID/EXE holds a live instruction
wb_en_o, mem_r_o, mem_w_o, s_o, b_o  out  1  registered controls
exe_cmd_o  out  4  ALU command
pc_o  out  DATA_W  registered pc_in
rn_val_o, rm_val_o  out  DATA_W  operand values (rm_val_o = Rd for STR)
imm_o  out  1  instr[25]
sh_opr_o  out  12  instr[11:0]
simm24_o  out  24  instr[23:0]
dest_o, src1_o, src2_o  out  RA_W  Rd, Rn, and Rm-or-Rd, for the forwarding unit
sr_o  out  4  registered sr_in

Behaviour:
- Instruction fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
- Condition: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL per ARM; 1111 is false.
- Control, mode 00, opcode -> exe_cmd:
  - MOV 1101->0001; MVN 1111->1001; ADD 0100->0010; ADC 0101->0011; SUB 0010->0100; SBC 0110->0101
  - AND 0000->0110; ORR 1100->0111; EOR 0001->1000; CMP 1010->0100; TST 1000->0110
  - wb=1 except CMP/TST; s=S; undefined opcodes give all controls 0.
- Control, mode 01: S=1 is LDR (wb, mem_r, exe_cmd 0010); S=0 is STR (mem_w, exe_cmd 0010); s=0.
- Control, mode 10: b=1, all else 0. Mode 11 is a NOP.
- Operand usage:
  - src2 = mem_w ? Rd : Rm.
  - uses_rn = 0 for MOV/MVN/branch/NOP, else 1.
  - two_src = ~I | mem_w.
- Hazard, FWD_EN=0: in_valid & [(uses_rn & Rn==exe_dst & exe_wb_en) | (two_src & src2==exe_dst & exe_wb_en) | the same two terms against mem_dst/mem_wb_en].
- Hazard, FWD_EN=1: only the EXE terms, each additionally gated with exe_mem_r.
- stall_out = hazard & ~flush.
- Register file: NREGS x DATA_W, async reset to 0, written at posedge clk when wb_en. Reads are combinational. Write-through: a read whose address equals wb_dst while wb_en is high returns wb_val in the same cycle.
- ID/EXE register at posedge, priority flush > bubble > load:
  - flush: out_valid=0 and all controls 0.
  - bubble (hazard, ~in_valid, or condition false): out_valid=0 and all controls 0; data fields are don't-care but are loaded.
  - load: all fields captured, out_valid=1.
- Latency is 1 cycle from instr to outputs.
- Reset: all registered outputs and every register-file entry go to 0 immediately; stall_out follows its inputs. Reset mid-stall discards the held instruction.
- A flush with a simultaneous hazard produces no stall and a bubble.

Decomposition:
- Package id_pkg holds: mode constants, opcode constants, exe_cmd constants, cond-code constants, and a struct for the control bundle {wb, mem_r, mem_w, s, b, exe_cmd}.
- Sub-module id_regfile (parametrised DATA_W/NREGS, 2 read ports, 1 write port, write-through bypass).
- Decode, condition check and hazard detection stay as combinational blocks inside id_stage_v2.

Test Plan:
- Reset: rst=0 with outputs preloaded -> all outputs 0 and rn_val_o=0 for every register. Release, then ADD R1,R2,#5 (0xE2821005) -> next cycle out_valid=1, exe_cmd_o=0010, wb_en_o=1, dest_o=1, src1_o=2.
- Write-through: wb_en=1, wb_dst=3, wb_val=0xDEAD with ADD R4,R3,R3 in the same cycle -> rn_val_o=rm_val_o=0xDEAD next cycle.
- Hazard, FWD_EN=0: exe_dst=2, exe_wb_en=1 with ADD R1,R2,#5 -> stall_out=1, out_valid=0 next cycle. Drop exe_wb_en -> loads normally.
- FWD_EN=1: same stimulus with exe_mem_r=0 -> no stall. With exe_mem_r=1 -> stall_out=1 and a bubble.
- Condition: ADDEQ with sr_in=0000 -> out_valid=0, wb_en_o=0. With sr_in=0100 -> executes normally.
- Flush priority: flush=1 with a hazard pending -> stall_out=0, out_valid=0. STR R5,[R6] (0xE5865000) -> src2_o=5, mem_w_o=1, wb_en_o=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants, control bundle type and condition evaluation
// for the ARM32 instruction-decode stage.
package id_pkg;

  // Instruction class, instr[27:26]
  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands understood by EXE
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       wb;
    logic       memR;
    logic       memW;
    logic       s;
    logic       b;
    logic [3:0] exeCmd;
  } ctrl_t;

  // Evaluate an ARM condition against {N,Z,C,V}; 1111 never passes.
  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: condPass = z;
      COND_NE: condPass = ~z;
      COND_CS: condPass = c;
      COND_CC: condPass = ~c;
      COND_MI: condPass = n;
      COND_PL: condPass = ~n;
      COND_VS: condPass = v;
      COND_VC: condPass = ~v;
      COND_HI: condPass = c & ~z;
      COND_LS: condPass = ~c | z;
      COND_GE: condPass = (n == v);
      COND_LT: condPass = (n != v);
      COND_GT: condPass = ~z & (n == v);
      COND_LE: condPass = z | (n != v);
      COND_AL: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two combinational read ports, one write port, and a
// write-through path so a same-cycle WB write is visible to the reader.
module id_regfile
  import id_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rdAddrA,
  input  logic [RA_W-1:0]   rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [RA_W-1:0]   wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage: cleared by reset, written at the clock edge by WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = (wrEn && (wrAddr == rdAddrA)) ? wrData : regs[rdAddrA];
  assign rdDataB = (wrEn && (wrAddr == rdAddrB)) ? wrData : regs[rdAddrB];

endmodule

// File: rtl/id_stage_v2.sv
// ARM32 decode stage: control decode, condition check, RAW hazard
// detection, register read and the ID/EXE pipeline register.
module id_stage_v2
  import id_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  parameter  int FWD_EN = 0,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        sr_in,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_dst,
  input  logic [DATA_W-1:0] wb_val,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r,
  input  logic [RA_W-1:0]   exe_dst,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dst,
  input  logic              flush,
  output logic              stall_out,
  output logic              out_valid,
  output logic              wb_en_o,
  output logic              mem_r_o,
  output logic              mem_w_o,
  output logic              s_o,
  output logic              b_o,
  output logic [3:0]        exe_cmd_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rn_val_o,
  output logic [DATA_W-1:0] rm_val_o,
  output logic              imm_o,
  output logic [11:0]       sh_opr_o,
  output logic [23:0]       simm24_o,
  output logic [RA_W-1:0]   dest_o,
  output logic [RA_W-1:0]   src1_o,
  output logic [RA_W-1:0]   src2_o,
  output logic [3:0]        sr_o
);

  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic              immBit;
  logic              sBit;
  logic [RA_W-1:0]   rnAddr;
  logic [RA_W-1:0]   rdAddr;
  logic [RA_W-1:0]   rmAddr;
  logic [RA_W-1:0]   src2Addr;
  ctrl_t             ctrl;
  logic              usesRn;
  logic              twoSrc;
  logic              condOk;
  logic              hazard;
  logic              hazExe;
  logic              hazMem;
  logic              bubble;
  logic [DATA_W-1:0] rnVal;
  logic [DATA_W-1:0] rmVal;

  assign mode     = instr[27:26];
  assign immBit   = instr[25];
  assign opcode   = instr[24:21];
  assign sBit     = instr[20];
  assign rnAddr   = RA_W'(instr[19:16]);
  assign rdAddr   = RA_W'(instr[15:12]);
  assign rmAddr   = RA_W'(instr[3:0]);
  assign src2Addr = ctrl.memW ? rdAddr : rmAddr;
  assign twoSrc   = ~immBit | ctrl.memW;
  assign condOk   = condPass(instr[31:28], sr_in);

  // Control decode and Rn usage from mode/opcode
  always_comb begin
    ctrl   = '0;
    usesRn = 1'b1;
    case (mode)
      MODE_ALU: begin
        ctrl.wb = 1'b1;
        ctrl.s  = sBit;
        case (opcode)
          OP_MOV: begin ctrl.exeCmd = CMD_MOV; usesRn = 1'b0; end
          OP_MVN: begin ctrl.exeCmd = CMD_MVN; usesRn = 1'b0; end
          OP_ADD: ctrl.exeCmd = CMD_ADD;
          OP_ADC: ctrl.exeCmd = CMD_ADC;
          OP_SUB: ctrl.exeCmd = CMD_SUB;
          OP_SBC: ctrl.exeCmd = CMD_SBC;
          OP_AND: ctrl.exeCmd = CMD_AND;
          OP_ORR: ctrl.exeCmd = CMD_ORR;
          OP_EOR: ctrl.exeCmd = CMD_EOR;
          OP_CMP: begin ctrl.exeCmd = CMD_SUB; ctrl.wb = 1'b0; end
          OP_TST: begin ctrl.exeCmd = CMD_AND; ctrl.wb = 1'b0; end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exeCmd = CMD_ADD;
        ctrl.wb     = sBit;
        ctrl.memR   = sBit;
        ctrl.memW   = ~sBit;
      end
      MODE_BR: begin
        ctrl.b = 1'b1;
        usesRn = 1'b0;
      end
      default: usesRn = 1'b0;
    endcase
  end

  // RAW hazard against EXE and MEM destinations
  always_comb begin
    hazExe = exe_wb_en & ((usesRn & (rnAddr == exe_dst)) | (twoSrc & (src2Addr == exe_dst)));
    hazMem = mem_wb_en & ((usesRn & (rnAddr == mem_dst)) | (twoSrc & (src2Addr == mem_dst)));
    if (FWD_EN != 0) hazard = in_valid & hazExe & exe_mem_r;
    else             hazard = in_valid & (hazExe | hazMem);
  end

  assign stall_out = hazard & ~flush;
  assign bubble    = hazard | ~in_valid | ~condOk;

  id_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) uRegfile (
    .clk    (clk),
    .rst    (rst),
    .rdAddrA(rnAddr),
    .rdAddrB(src2Addr),
    .rdDataA(rnVal),
    .rdDataB(rmVal),
    .wrEn   (wb_en),
    .wrAddr (wb_dst),
    .wrData (wb_val)
  );

  // ID/EXE register: data always captured, controls cleared on flush/bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      wb_en_o   <= 1'b0;
      mem_r_o   <= 1'b0;
      mem_w_o   <= 1'b0;
      s_o       <= 1'b0;
      b_o       <= 1'b0;
      exe_cmd_o <= '0;
      pc_o      <= '0;
      rn_val_o  <= '0;
      rm_val_o  <= '0;
      imm_o     <= 1'b0;
      sh_opr_o  <= '0;
      simm24_o  <= '0;
      dest_o    <= '0;
      src1_o    <= '0;
      src2_o    <= '0;
      sr_o      <= '0;
    end else begin
      pc_o     <= pc_in;
      rn_val_o <= rnVal;
      rm_val_o <= rmVal;
      imm_o    <= immBit;
      sh_opr_o <= instr[11:0];
      simm24_o <= instr[23:0];
      dest_o   <= rdAddr;
      src1_o   <= rnAddr;
      src2_o   <= src2Addr;
      sr_o     <= sr_in;
      if (flush || bubble) begin
        out_valid <= 1'b0;
        wb_en_o   <= 1'b0;
        mem_r_o   <= 1'b0;
        mem_w_o   <= 1'b0;
        s_o       <= 1'b0;
        b_o       <= 1'b0;
        exe_cmd_o <= '0;
      end else begin
        out_valid <= 1'b1;
        wb_en_o   <= ctrl.wb;
        mem_r_o   <= ctrl.memR;
        mem_w_o   <= ctrl.memW;
        s_o       <= ctrl.s;
        b_o       <= ctrl.b;
        exe_cmd_o <= ctrl.exeCmd;
      end
    end
  end

endmodule
